// File: rtl/mc14500_pkg.sv
// Shared opcode constants and sequencer state encoding for the MC14500 sequencer.
package mc14500_pkg;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDC = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ORC  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_STOC = 4'h9;
  localparam logic [3:0] OP_IEN  = 4'hA;
  localparam logic [3:0] OP_OEN  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_t;

endpackage

// File: rtl/mc14500_ret_stack.sv
// LIFO of return addresses for JMP/RTN; push when full and pop when empty are ignored.
module mc14500_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_dec;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);
  assign sp_dec = sp - SP_W'(1);
  assign wr_idx = IDX_W'(sp);
  assign rd_idx = IDX_W'(sp_dec);
  assign top    = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp_dec;
    end
  end

  // Entries are only meaningful below sp, so the storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (push && !full && !reset) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/mc14500_sequencer.sv
// Four-cycle instruction sequencer around an MC14500-style logic unit:
// fetches from ROM, strobes the LU, stores outputs and handles JMP/RTN/SKZ flow.
module mc14500_sequencer
  import mc14500_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int SEL_W       = 3,
  parameter int STACK_DEPTH = 4,
  localparam int IW     = 5 + SEL_W,
  localparam int IN_CH  = 2**SEL_W,
  localparam int OUT_CH = 2**SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IW-1:0]     rom_data,
  input  logic [IN_CH-1:0]  in_ch,
  output logic [OUT_CH-1:0] out_q,
  output logic [3:0]        lu_instruction,
  output logic              lu_data_in,
  output logic              lu_strobe,
  input  logic              lu_result,
  input  logic              lu_write_mode,
  input  logic              lu_data_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              jmp_pulse,
  output logic              rtn_pulse,
  output logic              halted,
  output logic              stack_err
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [IW-1:0]     ir;

  logic [3:0]        ir_op;
  logic              ir_chip;
  logic [SEL_W-1:0]  ir_port;
  logic [3:0]        rom_op;
  logic              rom_chip;
  logic [SEL_W-1:0]  rom_port;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jmp_target;
  logic              stk_push;
  logic              stk_pop;
  logic              stk_full;
  logic              stk_empty;
  logic [ADDR_W-1:0] stk_top;

  assign ir_op    = ir[IW-1 -: 4];
  assign ir_chip  = ir[SEL_W];
  assign ir_port  = ir[SEL_W-1:0];
  assign rom_op   = rom_data[IW-1 -: 4];
  assign rom_chip = rom_data[SEL_W];
  assign rom_port = rom_data[SEL_W-1:0];

  assign pc_out = pc;
  assign pc_inc = pc + ADDR_W'(1);

  // Jump target is the {port, chip} page number left-aligned in the address.
  generate
    if (ADDR_W > SEL_W) begin : g_page_shift
      assign jmp_target = ADDR_W'({ir_port, ir_chip}) << (ADDR_W - SEL_W - 1);
    end else begin : g_page_trunc
      logic [SEL_W:0] page;
      assign page       = {ir_port, ir_chip};
      assign jmp_target = page[SEL_W -: ADDR_W];
    end
  endgenerate

  assign stk_push = (state == ST_WB) && (ir_op == OP_JMP) && !stk_full;
  assign stk_pop  = (state == ST_WB) && (ir_op == OP_RTN) && !stk_empty;

  mc14500_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .full      (stk_full),
    .empty     (stk_empty),
    .top       (stk_top)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_HALT;
      pc             <= '0;
      rom_addr       <= '0;
      ir             <= '0;
      out_q          <= '0;
      lu_instruction <= '0;
      lu_data_in     <= 1'b0;
      lu_strobe      <= 1'b0;
      jmp_pulse      <= 1'b0;
      rtn_pulse      <= 1'b0;
      halted         <= 1'b1;
      stack_err      <= 1'b0;
    end else begin
      lu_strobe <= 1'b0;
      jmp_pulse <= 1'b0;
      rtn_pulse <= 1'b0;
      case (state)
        ST_HALT: begin
          if (run) begin
            state  <= ST_FETCH;
            halted <= 1'b0;
          end
        end
        ST_FETCH: begin
          rom_addr <= pc;
          if (!run) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state <= ST_DECODE;
          end
        end
        // LU operands are registered from the ROM word so they are valid throughout EXEC.
        ST_DECODE: begin
          ir             <= rom_data;
          lu_instruction <= rom_op;
          lu_data_in     <= rom_chip ? out_q[rom_port] : in_ch[rom_port];
          lu_strobe      <= 1'b1;
          state          <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= ST_WB;
        end
        ST_WB: begin
          case (ir_op)
            OP_STO, OP_STOC: begin
              if (lu_write_mode && ir_chip) out_q[ir_port] <= lu_data_out;
              pc <= pc_inc;
            end
            OP_JMP: begin
              pc        <= jmp_target;
              jmp_pulse <= 1'b1;
              if (stk_full) stack_err <= 1'b1;
            end
            OP_RTN: begin
              rtn_pulse <= 1'b1;
              if (stk_empty) begin
                pc        <= pc_inc;
                stack_err <= 1'b1;
              end else begin
                pc <= stk_top;
              end
            end
            OP_SKZ: begin
              pc <= lu_result ? pc_inc : pc + ADDR_W'(2);
            end
            default: begin
              pc <= pc_inc;
            end
          endcase
          state <= ST_FETCH;
        end
        default: begin
          state  <= ST_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Directed bench for mc14500_sequencer with a small LD/LDC logic-unit model and a ROM array.
module tb_mc14500_sequencer;
  import mc14500_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [6:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] in_ch;
  logic [7:0] out_q;
  logic [3:0] lu_instruction;
  logic       lu_data_in;
  logic       lu_strobe;
  logic       lu_result;
  logic       lu_write_mode;
  logic       lu_data_out;
  logic [6:0] pc_out;
  logic       jmp_pulse;
  logic       rtn_pulse;
  logic       halted;
  logic       stack_err;

  logic [7:0] rom [128];
  logic       rr;
  logic       wm;

  int n_chk  = 0;
  int n_pass = 0;
  int n_strb = 0;
  int n_jmp  = 0;
  int n_rtn  = 0;

  always #5 clk = ~clk;

  mc14500_sequencer #(
    .ADDR_W      (7),
    .SEL_W       (3),
    .STACK_DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .in_ch          (in_ch),
    .out_q          (out_q),
    .lu_instruction (lu_instruction),
    .lu_data_in     (lu_data_in),
    .lu_strobe      (lu_strobe),
    .lu_result      (lu_result),
    .lu_write_mode  (lu_write_mode),
    .lu_data_out    (lu_data_out),
    .pc_out         (pc_out),
    .jmp_pulse      (jmp_pulse),
    .rtn_pulse      (rtn_pulse),
    .halted         (halted),
    .stack_err      (stack_err)
  );

  assign rom_data = rom[rom_addr];

  // Logic unit model: LD/LDC load RR on the strobe; stores drive RR out.
  always_ff @(posedge clk) begin
    if (reset) rr <= 1'b0;
    else if (lu_strobe) begin
      if (lu_instruction == OP_LD)  rr <= lu_data_in;
      if (lu_instruction == OP_LDC) rr <= ~lu_data_in;
    end
  end
  assign lu_result     = rr;
  assign lu_data_out   = rr;
  assign lu_write_mode = wm;

  function automatic logic [7:0] ins(input logic [3:0] op, input logic chip, input logic [2:0] port);
    return {op, chip, port};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (lu_strobe) n_strb++;
      if (jmp_pulse) n_jmp++;
      if (rtn_pulse) n_rtn++;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    step(2);
    reset  = 1'b0;
    n_strb = 0;
    n_jmp  = 0;
    n_rtn  = 0;
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    in_ch = 8'h00;
    wm    = 1'b1;
    clear_rom();
    do_reset();

    check_eq("rst_halted", halted, 1);
    check_eq("rst_pc", pc_out, 0);
    check_eq("rst_rom_addr", rom_addr, 0);
    check_eq("rst_out_q", out_q, 0);
    check_eq("rst_lu", {lu_instruction, lu_data_in, lu_strobe, jmp_pulse, rtn_pulse, stack_err}, 0);

    // LD in_ch[2] then STO to out_q[5]
    rom[0] = ins(OP_LD, 1'b0, 3'd2);
    rom[1] = ins(OP_STO, 1'b1, 3'd5);
    in_ch = 8'h04;
    run = 1'b1;
    step(1);
    check_eq("run_leaves_halt", halted, 0);
    n_strb = 0;
    step(8);
    check_eq("ld_sto_out_q", out_q, 8'h20);
    check_eq("ld_sto_pc", pc_out, 2);
    check_eq("ld_sto_strobes", n_strb, 2);
    step(8);
    check_eq("nop_strobes", n_strb, 4);

    // Store with write mode off is dropped
    do_reset();
    wm = 1'b0;
    run = 1'b1;
    step(9);
    check_eq("sto_wm0_out_q", out_q, 0);
    wm = 1'b1;

    // Store to chip 0 is dropped
    do_reset();
    rom[1] = ins(OP_STO, 1'b0, 3'd5);
    run = 1'b1;
    step(9);
    check_eq("sto_chip0_out_q", out_q, 0);

    // JMP to page 0x30 and RTN back
    clear_rom();
    do_reset();
    rom[0]    = ins(OP_JMP, 1'b0, 3'd3);
    rom[7'h30] = ins(OP_RTN, 1'b0, 3'd0);
    run = 1'b1;
    step(5);
    check_eq("jmp_pc", pc_out, 7'h30);
    check_eq("jmp_pulse_seen", n_jmp, 1);
    step(1);
    check_eq("jmp_pulse_drop", jmp_pulse, 0);
    step(3);
    check_eq("rtn_pc", pc_out, 1);
    check_eq("rtn_pulse_on", rtn_pulse, 1);
    step(1);
    check_eq("rtn_pulse_cnt", n_rtn, 1);
    check_eq("jmp_rtn_err", stack_err, 0);

    // Five nested jumps overflow a 4-deep stack, then unwind past empty
    clear_rom();
    do_reset();
    rom[7'h00] = ins(OP_JMP, 1'b0, 3'd1);
    rom[7'h10] = ins(OP_JMP, 1'b0, 3'd2);
    rom[7'h20] = ins(OP_JMP, 1'b0, 3'd3);
    rom[7'h30] = ins(OP_JMP, 1'b0, 3'd4);
    rom[7'h40] = ins(OP_JMP, 1'b0, 3'd5);
    rom[7'h50] = ins(OP_RTN, 1'b0, 3'd0);
    rom[7'h31] = ins(OP_RTN, 1'b0, 3'd0);
    rom[7'h21] = ins(OP_RTN, 1'b0, 3'd0);
    rom[7'h11] = ins(OP_RTN, 1'b0, 3'd0);
    rom[7'h01] = ins(OP_RTN, 1'b0, 3'd0);
    run = 1'b1;
    step(17);
    check_eq("nest4_pc", pc_out, 7'h40);
    check_eq("nest4_err", stack_err, 0);
    step(4);
    check_eq("nest5_pc", pc_out, 7'h50);
    check_eq("nest5_err", stack_err, 1);
    step(4);
    check_eq("ovf_rtn_pc", pc_out, 7'h31);
    step(12);
    check_eq("unwind_pc", pc_out, 7'h01);
    step(4);
    check_eq("undf_pc", pc_out, 7'h02);
    check_eq("undf_err", stack_err, 1);
    check_eq("undf_rtn_cnt", n_rtn, 5);

    // SKZ at 0x7F wraps the pc
    clear_rom();
    rom[7'h00] = ins(OP_JMP, 1'b1, 3'd7);
    rom[7'h78] = ins(OP_LD, 1'b0, 3'd0);
    rom[7'h7F] = ins(OP_SKZ, 1'b0, 3'd0);
    in_ch = 8'h00;
    do_reset();
    run = 1'b1;
    step(33);
    check_eq("skz_at_pc", pc_out, 7'h7F);
    step(4);
    check_eq("skz0_wrap_pc", pc_out, 7'h01);
    in_ch = 8'h01;
    do_reset();
    run = 1'b1;
    step(37);
    check_eq("skz1_wrap_pc", pc_out, 7'h00);

    // Dropping run mid-instruction halts at the next FETCH
    clear_rom();
    in_ch = 8'h00;
    do_reset();
    run = 1'b1;
    step(3);
    run = 1'b0;
    step(2);
    check_eq("drop_wb_done_pc", pc_out, 1);
    check_eq("drop_not_halted", halted, 0);
    step(1);
    check_eq("drop_halted", halted, 1);
    step(3);
    check_eq("drop_pc_held", pc_out, 1);
    run = 1'b1;
    step(2);
    check_eq("resume_rom_addr", rom_addr, 1);
    step(3);
    check_eq("resume_pc", pc_out, 2);

    // Reset during WB of a store aborts it
    rom[0] = ins(OP_LD, 1'b0, 3'd2);
    rom[1] = ins(OP_STO, 1'b1, 3'd5);
    in_ch = 8'h04;
    do_reset();
    run = 1'b1;
    step(8);
    reset = 1'b1;
    run = 1'b0;
    step(1);
    reset = 1'b0;
    check_eq("wb_rst_out_q", out_q, 0);
    check_eq("wb_rst_pc", pc_out, 0);
    check_eq("wb_rst_halted", halted, 1);
    step(2);
    check_eq("wb_rst_stays", {halted, out_q}, 9'h100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
